// File: rtl/muldiv_hilo_pkg.sv
// Shared definitions for the multiply/divide sequencer: op codes, FSM states
// and the architectural register width.
package muldiv_hilo_pkg;

    localparam int unsigned CPU_REG_WIDTH = 32;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5,
        OP_MFHI  = 3'd6,
        OP_MFLO  = 3'd7
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL_RUN,
        S_MUL_FIX,
        S_DIV_START,
        S_DIV_WAIT
    } state_e;

    function automatic logic is_mul_op(input op_e o);
        return (o == OP_MULT) || (o == OP_MULTU);
    endfunction

endpackage

// File: rtl/muldiv_hilo_imul.sv
// Iterative W x W unsigned shift-add multiplier, one partial product per step.
// The low half of prod doubles as the multiplier shift register.
module muldiv_hilo_imul
    import muldiv_hilo_pkg::*;
#(
    parameter int unsigned W = CPU_REG_WIDTH
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           step,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [2*W-1:0] prod,
    output logic           last
);

    localparam int unsigned CW = $clog2(W + 1);

    logic [2*W-1:0] prod_q, prod_d;
    logic [W-1:0]   mcand_q, mcand_d;
    logic [CW-1:0]  count_q, count_d;
    logic [W:0]     sum;

    always_comb begin
        prod_d  = prod_q;
        mcand_d = mcand_q;
        count_d = count_q;
        // Carry out of the upper-half add is kept by shifting it into the MSB.
        sum     = {1'b0, prod_q[2*W-1:W]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
        if (start) begin
            prod_d  = {{W{1'b0}}, b};
            mcand_d = a;
            count_d = CW'(W);
        end else if (step) begin
            prod_d  = {sum, prod_q[W-1:1]};
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prod_q  <= '0;
            mcand_q <= '0;
            count_q <= '0;
        end else begin
            prod_q  <= prod_d;
            mcand_q <= mcand_d;
            count_q <= count_d;
        end
    end

    assign prod = prod_q;
    assign last = (count_q == CW'(1));

endmodule

// File: rtl/muldiv_hilo.sv
// HI/LO register file and multiply/divide sequencer for the execute stage:
// signed fixup around the internal multiplier and start/ready handshake to the divider.
module muldiv_hilo
    import muldiv_hilo_pkg::*;
#(
    parameter int unsigned W = CPU_REG_WIDTH
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           op_valid,
    input  logic [2:0]     op,
    input  logic [W-1:0]   rs_val,
    input  logic [W-1:0]   rt_val,
    input  logic           abort,
    output logic           busy,
    output logic           rd_valid,
    output logic [W-1:0]   rd_val,
    output logic           div_start,
    output logic           div_signd,
    output logic [W-1:0]   div_dividend,
    output logic [W-1:0]   div_divider,
    input  logic           div_ready,
    input  logic [2*W-1:0] div_remquot
);

    state_e         state_q, state_d;
    logic [W-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic [W-1:0]   rd_val_q, rd_val_d;
    logic [W-1:0]   dvd_q, dvd_d, dvs_q, dvs_d;
    logic           busy_q, busy_d;
    logic           rd_valid_q, rd_valid_d;
    logic           div_start_q, div_start_d;
    logic           signd_q, signd_d;
    logic           neg_q, neg_d;

    op_e            op_in;
    logic           accept;
    logic           rs_neg, rt_neg;
    logic           mul_start, mul_step, mul_last;
    logic [W-1:0]   mul_a, mul_b;
    logic [2*W-1:0] mul_prod, prod_fix;

    muldiv_hilo_imul #(.W(W)) u_imul (
        .clk   (clk),
        .rst   (rst),
        .start (mul_start),
        .step  (mul_step),
        .a     (mul_a),
        .b     (mul_b),
        .prod  (mul_prod),
        .last  (mul_last)
    );

    always_comb begin
        op_in     = op_e'(op);
        accept    = op_valid && !busy_q && !abort;
        // Signed multiply runs on magnitudes; the sign is reapplied in MUL_FIX.
        rs_neg    = (op_in == OP_MULT) && rs_val[W-1];
        rt_neg    = (op_in == OP_MULT) && rt_val[W-1];
        mul_a     = rs_neg ? (~rs_val + W'(1)) : rs_val;
        mul_b     = rt_neg ? (~rt_val + W'(1)) : rt_val;
        mul_start = accept && is_mul_op(op_in);
        mul_step  = (state_q == S_MUL_RUN);
        prod_fix  = neg_q ? ((2*W)'(0) - mul_prod) : mul_prod;

        state_d     = state_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        rd_val_d    = rd_val_q;
        rd_valid_d  = 1'b0;
        div_start_d = 1'b0;
        signd_d     = signd_q;
        dvd_d       = dvd_q;
        dvs_d       = dvs_q;
        neg_d       = neg_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    case (op_in)
                        OP_MULT, OP_MULTU: begin
                            neg_d   = rs_neg ^ rt_neg;
                            state_d = S_MUL_RUN;
                        end
                        OP_DIV, OP_DIVU: begin
                            dvd_d       = rs_val;
                            dvs_d       = rt_val;
                            signd_d     = (op_in == OP_DIV);
                            div_start_d = 1'b1;
                            state_d     = S_DIV_START;
                        end
                        OP_MTHI: hi_d = rs_val;
                        OP_MTLO: lo_d = rs_val;
                        OP_MFHI: begin
                            rd_valid_d = 1'b1;
                            rd_val_d   = hi_q;
                        end
                        OP_MFLO: begin
                            rd_valid_d = 1'b1;
                            rd_val_d   = lo_q;
                        end
                        default: ;
                    endcase
                end
            end
            S_MUL_RUN: begin
                if (mul_last) state_d = S_MUL_FIX;
            end
            S_MUL_FIX: begin
                {hi_d, lo_d} = prod_fix;
                state_d      = S_IDLE;
            end
            // div_ready still reflects the previous operation here, so it is not looked at.
            S_DIV_START: state_d = S_DIV_WAIT;
            S_DIV_WAIT: begin
                if (div_ready) begin
                    hi_d    = div_remquot[2*W-1:W];
                    lo_d    = div_remquot[W-1:0];
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            hi_q        <= '0;
            lo_q        <= '0;
            rd_val_q    <= '0;
            rd_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
            div_start_q <= 1'b0;
            signd_q     <= 1'b0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            neg_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            rd_val_q    <= rd_val_d;
            rd_valid_q  <= rd_valid_d;
            busy_q      <= busy_d;
            div_start_q <= div_start_d;
            signd_q     <= signd_d;
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
            neg_q       <= neg_d;
        end
    end

    assign busy         = busy_q;
    assign rd_valid     = rd_valid_q;
    assign rd_val       = rd_val_q;
    assign div_start    = div_start_q;
    assign div_signd    = signd_q;
    assign div_dividend = dvd_q;
    assign div_divider  = dvs_q;

endmodule
